// File: rtl/seq_detect_fsm_if.sv
// Serial pattern-detector bus: bit-stream inputs and detection results.
interface seq_detect_fsm_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             din;
    logic             mode_ovl;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, din, mode_ovl, clr,
        input  match, match_cnt, cnt_sat
    );

    modport slave (
        input  en, din, mode_ovl, clr,
        output match, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector with overlap/non-overlap modes, bit-valid
// qualifier, synchronous clear and a saturating hit counter.
module seq_detect_fsm #(
    parameter int unsigned          LEN     = 4,
    parameter logic [LEN-1:0]       PATTERN = 4'b1011,
    parameter int unsigned          CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    seq_detect_fsm_if.slave  bus
);

    localparam int unsigned      FillW    = $clog2(LEN + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(LEN);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {StFilling, StArmed} state_e;

    state_e           state_q, state_d;
    logic [LEN-1:0]   hist_q, hist_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [LEN-1:0]   hist_nx;
    logic [FillW-1:0] fill_nx;
    logic             hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFilling;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        hist_nx = {hist_q[LEN-2:0], bus.din};
        fill_nx = (state_q == StArmed) ? FillFull : fill_q + FillW'(1);
        hit     = (fill_nx == FillFull) && (hist_nx == PATTERN);

        if (bus.clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
        end else if (bus.en) begin
            hist_d  = hist_nx;
            fill_d  = fill_nx;
            match_d = hit;
            if (hit) begin
                // Non-overlapping: demand LEN fresh bits before the next compare.
                if (!bus.mode_ovl) fill_d = '0;
                if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
            end
            sat_d = sat_q | (cnt_d == CntMax);
        end

        state_d = (fill_d == FillFull) ? StArmed : StFilling;
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Randomized + directed bench: two detectors (8-bit and 2-bit counters) against a
// queue-based reference model of the last accepted bits.
module tb_seq_detect_fsm;

    localparam int unsigned LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, din = 1'b0, mode_ovl = 1'b1, clr = 1'b0;

    seq_detect_fsm_if #(.CNT_W(8)) bus8 ();
    seq_detect_fsm_if #(.CNT_W(2)) bus2 ();

    assign bus8.en = en;  assign bus8.din = din;
    assign bus8.mode_ovl = mode_ovl;  assign bus8.clr = clr;
    assign bus2.en = en;  assign bus2.din = din;
    assign bus2.mode_ovl = mode_ovl;  assign bus2.clr = clr;

    seq_detect_fsm #(.LEN(LEN), .PATTERN(4'b1011), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_detect_fsm #(.LEN(LEN), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: recent accepted bits, oldest first.
    logic [LEN-1:0] pat = 4'b1011;
    logic           hq[$];
    int             cnt8 = 0, cnt2 = 0;
    logic           exp_match = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_match"},  32'(bus8.match),     32'(exp_match));
        check({tag, "_match2"}, 32'(bus2.match),     32'(exp_match));
        check({tag, "_cnt8"},   32'(bus8.match_cnt), 32'(cnt8));
        check({tag, "_sat8"},   32'(bus8.cnt_sat),   32'(cnt8 == 255));
        check({tag, "_cnt2"},   32'(bus2.match_cnt), 32'(cnt2));
        check({tag, "_sat2"},   32'(bus2.cnt_sat),   32'(cnt2 == 3));
    endtask

    function automatic logic pattern_seen();
        if (hq.size() != LEN) return 1'b0;
        for (int i = 0; i < LEN; i++)
            if (hq[i] != pat[LEN-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hq.delete();
        cnt8 = 0;
        cnt2 = 0;
        exp_match = 1'b0;
    endtask

    task automatic cycle(input logic e, input logic d, input logic m, input logic c,
                         input string tag);
        en = e; din = d; mode_ovl = m; clr = c;
        @(posedge clk);
        exp_match = 1'b0;
        if (c) begin
            hq.delete();
            cnt8 = 0;
            cnt2 = 0;
        end else if (e) begin
            hq.push_back(d);
            if (hq.size() > LEN) void'(hq.pop_front());
            if (pattern_seen()) begin
                exp_match = 1'b1;
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3) cnt2++;
                if (!m) hq.delete();
            end
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        rst = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        rst = 1'b1;
    endtask

    task automatic send_stream(input logic [6:0] bits, input int n, input logic m,
                               input int gap, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b1, bits[i], m, 1'b0, tag);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, m, 1'b0, tag);
        end
    endtask

    logic [6:0] t1_bits;
    logic [3:0] t4_bits;

    initial begin
        t1_bits = 7'b1011011;
        t4_bits = 4'b1011;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // T1 overlap
        send_stream(t1_bits, 7, 1'b1, 0, "t1");
        check("t1_total", 32'(bus8.match_cnt), 32'd2);

        // T2 non-overlap
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "t2_clr");
        send_stream(t1_bits, 7, 1'b0, 0, "t2");
        check("t2_total", 32'(bus8.match_cnt), 32'd1);

        // T3 en gaps
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "t3_clr");
        send_stream(t1_bits, 7, 1'b1, 3, "t3");
        check("t3_total", 32'(bus8.match_cnt), 32'd2);

        // T4 saturation on the 2-bit counter
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "t4_clr");
        for (int k = 0; k < 5; k++) send_stream({3'b0, t4_bits}, 4, 1'b0, 0, "t4");
        check("t4_cnt2", 32'(bus2.match_cnt), 32'd3);
        check("t4_sat2", 32'(bus2.cnt_sat), 32'd1);
        check("t4_cnt8", 32'(bus8.match_cnt), 32'd5);

        // T5 reset mid-stream
        send_stream(7'b0000101, 3, 1'b1, 0, "t5_pre");
        async_reset("t5_rst");
        check("t5_cnt_zero", 32'(bus8.match_cnt), 32'd0);
        send_stream(7'b0001011, 4, 1'b1, 0, "t5_post");
        check("t5_total", 32'(bus8.match_cnt), 32'd1);

        // T6 clr beats the completing bit
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "t6_clr0");
        send_stream(7'b0000101, 3, 1'b1, 0, "t6_pre");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, "t6_clr");
        check("t6_nomatch", 32'(bus8.match), 32'd0);
        send_stream(7'b0001011, 4, 1'b1, 0, "t6_post");
        check("t6_total", 32'(bus8.match_cnt), 32'd1);

        // Random stream: pattern-biased data, gaps, mode flips, rare clr/reset
        for (int i = 0; i < 4000; i++) begin
            logic e, d, m, c;
            e = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 9) < 6);
            m = ($urandom_range(0, 63) < 40) ? 1'b1 : 1'b0;
            c = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
            cycle(e, d, m, c, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
